// File: rtl/md5_search_controller.sv
// Issues candidate base words over a programmable range to NUM_PIPES MD5 pipelines and
// qualifies their match flags with a tagged delay line that mirrors pipeline latency.
module md5_search_controller #(
    parameter int unsigned NUM_PIPES = 2,
    parameter int unsigned CNT_WIDTH = 29,
    parameter int unsigned LATENCY   = 66
) (
    input  logic                                     CLK,
    input  logic                                     reset,
    input  logic                                     enable,
    input  logic                                     pause,
    input  logic [CNT_WIDTH-1:0]                     range_start,
    input  logic [CNT_WIDTH-1:0]                     range_end,
    output logic [CNT_WIDTH-1:0]                     candidate_base,
    output logic                                     candidate_valid,
    input  logic [NUM_PIPES-1:0]                     found_vec,
    output logic [CNT_WIDTH+$clog2(NUM_PIPES)-1:0]   found_value,
    output logic                                     status_running,
    output logic                                     status_paused,
    output logic                                     status_warming,
    output logic                                     status_draining,
    output logic                                     status_found,
    output logic                                     status_done
);

    localparam int unsigned LANE_BITS = $clog2(NUM_PIPES);
    localparam int unsigned LW        = (LANE_BITS > 0) ? LANE_BITS : 1;
    localparam int unsigned FV_W      = CNT_WIDTH + LANE_BITS;

    typedef enum logic [2:0] {StIdle, StRun, StPause, StDrain, StDone} state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] base_q, base_d;
    logic [CNT_WIDTH-1:0] end_q, end_d;
    logic                 valid_q, valid_d;
    logic [FV_W-1:0]      fv_q, fv_d;
    logic                 running_q, running_d;
    logic                 paused_q, paused_d;
    logic                 warming_q, warming_d;
    logic                 draining_q, draining_d;
    logic                 found_q, found_d;
    logic                 done_q, done_d;

    logic [LATENCY-1:0]   tag_q;
    logic [CNT_WIDTH-1:0] tag_base_q [LATENCY];
    logic                 tag_clear;
    logic                 tags_pending;
    logic                 hit;
    logic [LW-1:0]        hit_lane;
    logic [FV_W-1:0]      hit_value;

    // Pending looks at the line's next contents so DONE lands the cycle after the last tag exits.
    always_comb begin
        hit_lane = '0;
        for (int i = int'(NUM_PIPES) - 1; i >= 0; i--) begin
            if (found_vec[i]) hit_lane = LW'(i);
        end
        hit       = tag_q[LATENCY-1] && (|found_vec);
        hit_value = (FV_W'(tag_base_q[LATENCY-1]) << LANE_BITS) | FV_W'(hit_lane);
        tags_pending = valid_q;
        for (int i = 0; i < int'(LATENCY) - 1; i++) begin
            tags_pending = tags_pending | tag_q[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        end_d     = end_q;
        valid_d   = 1'b0;
        fv_d      = fv_q;
        found_d   = found_q;
        done_d    = done_q;
        warming_d = 1'b0;
        tag_clear = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    tag_clear = 1'b1;
                    found_d   = 1'b0;
                    fv_d      = '0;
                    if (range_start <= range_end) begin
                        end_d     = range_end;
                        base_d    = range_start;
                        valid_d   = 1'b1;
                        done_d    = 1'b0;
                        warming_d = 1'b1;
                        state_d   = StRun;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StRun, StPause, StDrain: begin
                if (!enable) begin
                    tag_clear = 1'b1;
                    found_d   = 1'b0;
                    done_d    = 1'b0;
                    fv_d      = '0;
                    state_d   = StIdle;
                end else if (hit) begin
                    fv_d    = hit_value;
                    found_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    warming_d = warming_q && !tag_q[LATENCY-1];
                    if (state_q == StRun) begin
                        // Last base stays put so an all-ones range_end never wraps.
                        if (base_q == end_q) begin
                            state_d = StDrain;
                        end else begin
                            base_d = base_q + CNT_WIDTH'(1);
                            if (pause) state_d = StPause;
                            else       valid_d = 1'b1;
                        end
                    end else if (state_q == StPause) begin
                        if (!pause) begin
                            valid_d = 1'b1;
                            state_d = StRun;
                        end
                    end else if (!tags_pending) begin
                        found_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (!enable) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        running_d  = (state_d == StRun) || (state_d == StDrain);
        paused_d   = (state_d == StPause);
        draining_d = (state_d == StDrain);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            base_q     <= '0;
            end_q      <= '0;
            valid_q    <= 1'b0;
            fv_q       <= '0;
            running_q  <= 1'b0;
            paused_q   <= 1'b0;
            warming_q  <= 1'b0;
            draining_q <= 1'b0;
            found_q    <= 1'b0;
            done_q     <= 1'b0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            end_q      <= end_d;
            valid_q    <= valid_d;
            fv_q       <= fv_d;
            running_q  <= running_d;
            paused_q   <= paused_d;
            warming_q  <= warming_d;
            draining_q <= draining_d;
            found_q    <= found_d;
            done_q     <= done_d;
            if (tag_clear) begin
                tag_q <= '0;
            end else begin
                tag_q[0] <= valid_q;
                for (int i = 1; i < int'(LATENCY); i++) tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        tag_base_q[0] <= base_q;
        for (int i = 1; i < int'(LATENCY); i++) tag_base_q[i] <= tag_base_q[i-1];
    end

    assign candidate_base  = base_q;
    assign candidate_valid = valid_q;
    assign found_value     = fv_q;
    assign status_running  = running_q;
    assign status_paused   = paused_q;
    assign status_warming  = warming_q;
    assign status_draining = draining_q;
    assign status_found    = found_q;
    assign status_done     = done_q;

endmodule

// File: tb/tb_md5_search_controller.sv
// Bench for md5_search_controller: directed scenarios plus random searches, all checked
// against a cycle-indexed issue-history model of the search rules.
module tb_md5_search_controller;

    localparam int NP = 2;
    localparam int CW = 8;
    localparam int L  = 4;

    localparam int PI  = 0;
    localparam int PR  = 1;
    localparam int PP  = 2;
    localparam int PD  = 3;
    localparam int PDN = 4;

    logic          CLK = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          pause = 1'b0;
    logic [CW-1:0] range_start = '0;
    logic [CW-1:0] range_end = '0;
    logic [NP-1:0] found_vec = '0;
    logic [CW-1:0] candidate_base;
    logic          candidate_valid;
    logic [CW:0]   found_value;
    logic          status_running, status_paused, status_warming;
    logic          status_draining, status_found, status_done;

    int checks = 0;
    int errors = 0;

    // Model: phase plus a history of which base was issued in which cycle.
    int            ph;
    int            cyc = 0;
    int            clear_cyc;
    int            first_iss = -100;
    int            last_iss = -100;
    int            hist[int];
    logic [CW-1:0] m_end, m_base;
    logic          m_valid, m_found, m_done;
    logic [CW:0]   m_fv;

    md5_search_controller #(
        .NUM_PIPES(NP),
        .CNT_WIDTH(CW),
        .LATENCY  (L)
    ) dut (
        .CLK            (CLK),
        .reset          (reset),
        .enable         (enable),
        .pause          (pause),
        .range_start    (range_start),
        .range_end      (range_end),
        .candidate_base (candidate_base),
        .candidate_valid(candidate_valid),
        .found_vec      (found_vec),
        .found_value    (found_value),
        .status_running (status_running),
        .status_paused  (status_paused),
        .status_warming (status_warming),
        .status_draining(status_draining),
        .status_found   (status_found),
        .status_done    (status_done)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic logic [23:0] dut_vec();
        return {candidate_valid, candidate_base, found_value, status_running, status_paused,
                status_warming, status_draining, status_found, status_done};
    endfunction

    function automatic logic [23:0] model_vec();
        logic act;
        act = (ph == PR) || (ph == PP) || (ph == PD);
        return {m_valid, m_base, m_fv, (ph == PR) || (ph == PD), ph == PP,
                act && (cyc <= first_iss + L), ph == PD, m_found, m_done};
    endfunction

    // What the pipeline output stage holds this cycle, regardless of qualification.
    function automatic bit out_base_is(input logic [CW-1:0] b);
        return hist.exists(cyc - L) && (hist[cyc - L] == int'(b));
    endfunction

    task automatic model_reset();
        ph        = PI;
        m_valid   = 1'b0;
        m_base    = '0;
        m_end     = '0;
        m_fv      = '0;
        m_found   = 1'b0;
        m_done    = 1'b0;
        clear_cyc = cyc;
    endtask

    task automatic model_step();
        int   c;
        int   t;
        int   lane;
        bit   qual;
        logic nv;
        c  = cyc;
        t  = c - L;
        nv = 1'b0;
        if (m_valid) begin
            hist[c]  = int'(m_base);
            last_iss = c;
        end
        qual = hist.exists(t) && (t > clear_cyc);
        case (ph)
            PI: begin
                if (enable) begin
                    clear_cyc = c;
                    m_found   = 1'b0;
                    m_fv      = '0;
                    if (range_start <= range_end) begin
                        m_end     = range_end;
                        m_base    = range_start;
                        nv        = 1'b1;
                        m_done    = 1'b0;
                        first_iss = c + 1;
                        ph        = PR;
                    end else begin
                        m_done = 1'b1;
                        ph     = PDN;
                    end
                end
            end
            PR, PP, PD: begin
                if (!enable) begin
                    ph        = PI;
                    clear_cyc = c;
                    m_found   = 1'b0;
                    m_done    = 1'b0;
                    m_fv      = '0;
                end else if (qual && (found_vec != '0)) begin
                    lane = found_vec[0] ? 0 : 1;
                    m_fv    = 9'(hist[t] * NP + lane);
                    m_found = 1'b1;
                    m_done  = 1'b1;
                    ph      = PDN;
                end else if (ph == PR) begin
                    if (m_base == m_end) begin
                        ph = PD;
                    end else begin
                        m_base = m_base + 8'd1;
                        if (pause) ph = PP;
                        else       nv = 1'b1;
                    end
                end else if (ph == PP) begin
                    if (!pause) begin
                        ph = PR;
                        nv = 1'b1;
                    end
                end else if (c >= last_iss + L) begin
                    ph      = PDN;
                    m_found = 1'b0;
                    m_done  = 1'b1;
                end
            end
            default: begin
                if (!enable) ph = PI;
            end
        endcase
        m_valid = nv;
        cyc     = c + 1;
    endtask

    task automatic tick();
        @(posedge CLK);
        if (reset) cyc++;
        else       model_step();
        #1;
    endtask

    task automatic start(input logic [CW-1:0] s, input logic [CW-1:0] e);
        enable    = 1'b0;
        pause     = 1'b0;
        found_vec = '0;
        tick();
        tick();
        range_start = s;
        range_end   = e;
        enable      = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (dut_vec() !== 24'h0) begin
            errors++;
            $display("FAIL reset_init got=%h want=%h", dut_vec(), 24'h0);
        end
        tick();
        #2 reset = 1'b0;
        start(8'h10, 8'h1F);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL reset_run cyc=%0d got=%h want=%h", cyc, dut_vec(), model_vec());
            end
            tick();
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== 24'h0) begin
            errors++;
            $display("FAIL reset_async got=%h want=%h", dut_vec(), 24'h0);
        end
        model_reset();
        enable = 1'b0;
        tick();
        #2 reset = 1'b0;
        found_vec = 2'b11;
        for (int i = 0; i < L + 2; i++) begin
            tick();
            checks++;
            if (dut_vec() !== model_vec() || status_found !== 1'b0) begin
                errors++;
                $display("FAIL reset_stale cyc=%0d got=%h want=%h", cyc, dut_vec(), model_vec());
            end
        end
        found_vec = '0;
    endtask

    task automatic test_match();
        int   iss15;
        int   rise;
        logic v_at_rise;
        iss15     = -1;
        rise      = -1;
        v_at_rise = 1'bx;
        start(8'h10, 8'h1F);
        for (int i = 1; i <= 40 && rise < 0; i++) begin
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL match_trace cyc=%0d got=%h want=%h", cyc, dut_vec(), model_vec());
            end
            if (candidate_valid === 1'b1 && candidate_base === 8'h15) iss15 = i;
            if (status_found === 1'b1) begin
                rise      = i;
                v_at_rise = candidate_valid;
            end
            found_vec = out_base_is(8'h15) ? 2'b10 : 2'b00;
            tick();
        end
        found_vec = '0;
        checks++;
        if (iss15 != 6 || rise != 11 || v_at_rise !== 1'b0) begin
            errors++;
            $display("FAIL match_timing issue=%0d rise=%0d valid=%b want 6 11 0", iss15, rise,
                     v_at_rise);
        end
        checks++;
        if ({status_found, status_done, found_value} !== {1'b1, 1'b1, 9'h02B}) begin
            errors++;
            $display("FAIL match_value found=%b done=%b value=%h want 1 1 02b", status_found,
                     status_done, found_value);
        end
        enable = 1'b0;
        tick();
        checks++;
        if (dut_vec() !== model_vec() || status_done !== 1'b1 || found_value !== 9'h02B) begin
            errors++;
            $display("FAIL match_hold_idle got=%h want=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_drain();
        logic [11:0] obs;
        logic [11:0] expv;
        start(8'h00, 8'h03);
        for (int i = 1; i <= 9; i++) begin
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL drain_trace cyc=%0d got=%h want=%h", cyc, dut_vec(), model_vec());
            end
            obs  = {candidate_valid, status_draining, status_done, status_found,
                    candidate_valid ? candidate_base : 8'h00};
            expv = {1'(i <= 4), 1'(i >= 5 && i <= 8), 1'(i == 9), 1'b0,
                    (i <= 4) ? 8'(i - 1) : 8'h00};
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL drain_cycle%0d got=%h want=%h", i, obs, expv);
            end
            tick();
        end
    endtask

    task automatic test_pause();
        start(8'h10, 8'h1F);
        for (int i = 1; i <= 7; i++) begin
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL pause_trace cyc=%0d got=%h want=%h", cyc, dut_vec(), model_vec());
            end
            if (i >= 4 && i <= 6) begin
                checks++;
                if ({candidate_valid, candidate_base, status_paused} !== {1'b0, 8'h13, 1'b1}) begin
                    errors++;
                    $display("FAIL pause_hold cycle%0d valid=%b base=%h paused=%b want 0 13 1", i,
                             candidate_valid, candidate_base, status_paused);
                end
            end
            if (i == 7) begin
                checks++;
                if ({status_found, found_value, status_paused} !== {1'b1, 9'h022, 1'b0}) begin
                    errors++;
                    $display("FAIL pause_match found=%b value=%h paused=%b want 1 022 0",
                             status_found, found_value, status_paused);
                end
            end
            pause     = (i >= 3 && i <= 5);
            found_vec = out_base_is(8'h11) ? 2'b01 : 2'b00;
            tick();
        end
        pause     = 1'b0;
        found_vec = '0;
    endtask

    task automatic test_lane_priority();
        start(8'h00, 8'h0F);
        for (int i = 0; i < 30 && status_done !== 1'b1; i++) begin
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL lane_trace cyc=%0d got=%h want=%h", cyc, dut_vec(), model_vec());
            end
            found_vec = out_base_is(8'h07) ? 2'b11 : 2'b00;
            tick();
        end
        found_vec = '0;
        checks++;
        if ({status_done, status_found, found_value} !== {1'b1, 1'b1, 9'h00E}) begin
            errors++;
            $display("FAIL lane_priority done=%b found=%b value=%h want 1 1 00e", status_done,
                     status_found, found_value);
        end
        start(8'h05, 8'h04);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dut_vec() !== model_vec() ||
                {status_done, status_found, candidate_valid, found_value} !==
                {1'b1, 1'b0, 1'b0, 9'h000}) begin
                errors++;
                $display("FAIL empty_range cyc=%0d got=%h want=%h", cyc, dut_vec(), model_vec());
            end
            tick();
        end
    endtask

    task automatic test_abort();
        start(8'h20, 8'h3F);
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL abort_trace cyc=%0d got=%h want=%h", cyc, dut_vec(), model_vec());
            end
            if (i == 4 || i == 8) begin
                checks++;
                if ({status_running, status_paused, status_warming, status_draining, status_found,
                     status_done, candidate_valid, found_value} !== 16'h0) begin
                    errors++;
                    $display("FAIL abort_idle cycle%0d got=%h want=%h", i, dut_vec(),
                             {candidate_base, 16'h0});
                end
            end
            if (i == 3) enable = 1'b0;
            found_vec = (i >= 4 && i <= 7) ? 2'b11 : 2'b00;
            tick();
        end
        found_vec = '0;
    endtask

    task automatic test_random();
        int s;
        int e;
        int tgt;
        int tl;
        bit ended;
        for (int n = 0; n < 40; n++) begin
            s = int'($urandom_range(0, 255));
            e = s + int'($urandom_range(0, 24));
            if (e > 255) e = 255;
            if (n == 0) begin
                s = 248;
                e = 255;
            end
            if (n % 7 == 3 && s > 0) e = int'($urandom_range(0, s - 1));
            tgt = s + int'($urandom_range(0, 30));
            tl  = int'($urandom_range(0, 1));
            enable    = 1'b0;
            pause     = 1'b0;
            found_vec = '0;
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL rand_idle cyc=%0d got=%h want=%h", cyc, dut_vec(), model_vec());
            end
            range_start = 8'(s);
            range_end   = 8'(e);
            enable      = 1'b1;
            ended       = 1'b0;
            for (int k = 0; k < 120 && !ended; k++) begin
                tick();
                checks++;
                if (dut_vec() !== model_vec()) begin
                    errors++;
                    $display("FAIL rand_trace cyc=%0d got=%h want=%h", cyc, dut_vec(),
                             model_vec());
                end
                if (ph == PDN || ph == PI) begin
                    ended = 1'b1;
                end else begin
                    pause = ($urandom_range(0, 3) == 0);
                    if ($urandom_range(0, 59) == 0) enable = 1'b0;
                    if (out_base_is(8'(tgt))) begin
                        found_vec     = 2'b00;
                        found_vec[tl] = 1'b1;
                        if ($urandom_range(0, 1) == 1) found_vec = 2'b11;
                    end else begin
                        found_vec = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                    end
                end
            end
            if (!ended) begin
                checks++;
                errors++;
                $display("FAIL rand_timeout run=%0d got=%h want done or idle", n, dut_vec());
            end
        end
        enable    = 1'b0;
        pause     = 1'b0;
        found_vec = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_match();
        test_drain();
        test_pause();
        test_lane_priority();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
